// File: rtl/slot_pkg.sv
// ============================================================================
// Module : slot_pkg
// Shared field codes, status/issuer encodings and profile saturation constant
// Rev    : 1.0
// ============================================================================
`default_nettype none

package slot_pkg;

    localparam logic [2:0] c_FLD_SRC_ADDR = 3'd0;
    localparam logic [2:0] c_FLD_SRC_SIZE = 3'd1;
    localparam logic [2:0] c_FLD_DES_ADDR = 3'd2;
    localparam logic [2:0] c_FLD_DES_SIZE = 3'd3;
    localparam logic [2:0] c_FLD_ARM      = 3'd4;
    localparam logic [2:0] c_FLD_CLEAR    = 3'd5;
    localparam logic [2:0] c_RD_STATUS    = 3'd4;
    localparam logic [2:0] c_RD_PROFILE   = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } slot_status_e;

    typedef enum logic [1:0] {
        IS_SCAN  = 2'd0,
        IS_ISSUE = 2'd1,
        IS_RUN   = 2'd2
    } iss_state_e;

    // Profile counters saturate at all-ones; sliced to the counter width (<= 64).
    localparam logic [63:0] c_PROFILE_SAT = '1;

endpackage

`default_nettype wire

// File: rtl/slot_entry.sv
// ============================================================================
// Module : slot_entry
// One descriptor slot: fields, status, saturating profile counter, write decode
// Rev    : 1.0
// ============================================================================
`default_nettype none

module slot_entry
    import slot_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int PROFILE_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_wr_en,
    input  logic [2:0]                i_wr_field,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_set_running,
    input  logic                      i_set_done,
    input  logic                      i_prof_inc,
    output logic [SRC_ADDR_WIDTH-1:0] o_src_addr,
    output logic [SRC_SIZE_WIDTH-1:0] o_src_size,
    output logic [DST_ADDR_WIDTH-1:0] o_des_addr,
    output logic [DST_SIZE_WIDTH-1:0] o_des_size,
    output logic [1:0]                o_status,
    output logic [PROFILE_WIDTH-1:0]  o_profile,
    output logic                      o_wr_rej
);

    localparam logic [PROFILE_WIDTH-1:0] c_PROFILE_MAX = c_PROFILE_SAT[PROFILE_WIDTH-1:0];

    logic [SRC_ADDR_WIDTH-1:0] r_src_addr;
    logic [SRC_SIZE_WIDTH-1:0] r_src_size;
    logic [DST_ADDR_WIDTH-1:0] r_des_addr;
    logic [DST_SIZE_WIDTH-1:0] r_des_size;
    slot_status_e              r_status;
    logic [PROFILE_WIDTH-1:0]  r_profile;
    logic                      w_wr_ok;

    assign o_wr_rej = i_wr_en && ((r_status == ST_RUNNING) || (i_wr_field > c_FLD_CLEAR));
    assign w_wr_ok  = i_wr_en && !o_wr_rej;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_addr <= '0;
            r_src_size <= '0;
            r_des_addr <= '0;
            r_des_size <= '0;
            r_status   <= ST_EMPTY;
            r_profile  <= '0;
        end else begin
            if (w_wr_ok) begin
                case (i_wr_field)
                    c_FLD_SRC_ADDR: r_src_addr <= i_wr_data[SRC_ADDR_WIDTH-1:0];
                    c_FLD_SRC_SIZE: r_src_size <= i_wr_data[SRC_SIZE_WIDTH-1:0];
                    c_FLD_DES_ADDR: r_des_addr <= i_wr_data[DST_ADDR_WIDTH-1:0];
                    c_FLD_DES_SIZE: r_des_size <= i_wr_data[DST_SIZE_WIDTH-1:0];
                    c_FLD_ARM: begin
                        r_status  <= ST_PENDING;
                        r_profile <= '0;
                    end
                    c_FLD_CLEAR:    r_status <= ST_EMPTY;
                    default: ;
                endcase
            end
            if (i_prof_inc && (r_profile != c_PROFILE_MAX)) begin
                r_profile <= r_profile + PROFILE_WIDTH'(1);
            end
            // Issuer transitions override a same-cycle software status write.
            if (i_set_running) begin
                r_status <= ST_RUNNING;
            end else if (i_set_done) begin
                r_status <= ST_DONE;
            end
        end
    end

    assign o_src_addr = r_src_addr;
    assign o_src_size = r_src_size;
    assign o_des_addr = r_des_addr;
    assign o_des_size = r_des_size;
    assign o_status   = r_status;
    assign o_profile  = r_profile;

endmodule

`default_nettype wire

// File: rtl/slot_bank.sv
// ============================================================================
// Module : slot_bank
// Descriptor slot bank with round-robin issuer FSM and registered read port
// Rev    : 1.0
// ============================================================================
`default_nettype none

module slot_bank
    import slot_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int IDX_WIDTH      = $clog2(NUM_SLOTS),
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int PROFILE_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]      cfg_wr_idx,
    input  logic [2:0]                cfg_wr_field,
    input  logic [DATA_WIDTH-1:0]     cfg_wr_data,
    output logic                      cfg_wr_err,
    input  logic [IDX_WIDTH-1:0]      cfg_rd_idx,
    input  logic [2:0]                cfg_rd_field,
    output logic [DATA_WIDTH-1:0]     cfg_rd_data,
    input  logic                      seq_en,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [IDX_WIDTH-1:0]      iss_idx,
    output logic [SRC_ADDR_WIDTH-1:0] iss_src_addr,
    output logic [SRC_SIZE_WIDTH-1:0] iss_src_size,
    output logic [DST_ADDR_WIDTH-1:0] iss_des_addr,
    output logic [DST_SIZE_WIDTH-1:0] iss_des_size,
    input  logic                      exec_done,
    output logic                      busy,
    output logic                      done_pulse,
    output logic [IDX_WIDTH-1:0]      done_idx
);

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(NUM_SLOTS - 1);

    logic [SRC_ADDR_WIDTH-1:0] w_src_addr [NUM_SLOTS];
    logic [SRC_SIZE_WIDTH-1:0] w_src_size [NUM_SLOTS];
    logic [DST_ADDR_WIDTH-1:0] w_des_addr [NUM_SLOTS];
    logic [DST_SIZE_WIDTH-1:0] w_des_size [NUM_SLOTS];
    logic [1:0]                w_status   [NUM_SLOTS];
    logic [PROFILE_WIDTH-1:0]  w_profile  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]      w_wr_rej;

    iss_state_e           r_state;
    logic [IDX_WIDTH-1:0] r_ptr;
    logic                 w_handshake;
    logic                 w_finish;
    logic [IDX_WIDTH-1:0] w_ptr_next;

    assign w_handshake = (r_state == IS_ISSUE) && iss_ready;
    assign w_finish    = (r_state == IS_RUN) && exec_done;
    assign w_ptr_next  = (r_ptr == c_LAST_IDX) ? '0 : r_ptr + IDX_WIDTH'(1);

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            logic w_sel;
            assign w_sel = (r_ptr == IDX_WIDTH'(g));

            slot_entry #(
                .SRC_ADDR_WIDTH (SRC_ADDR_WIDTH),
                .SRC_SIZE_WIDTH (SRC_SIZE_WIDTH),
                .DST_ADDR_WIDTH (DST_ADDR_WIDTH),
                .DST_SIZE_WIDTH (DST_SIZE_WIDTH),
                .PROFILE_WIDTH  (PROFILE_WIDTH),
                .DATA_WIDTH     (DATA_WIDTH)
            ) u_entry (
                .clk           (clk),
                .reset         (reset),
                .i_wr_en       (cfg_wr_en && (cfg_wr_idx == IDX_WIDTH'(g))),
                .i_wr_field    (cfg_wr_field),
                .i_wr_data     (cfg_wr_data),
                .i_set_running (w_handshake && w_sel),
                .i_set_done    (w_finish && w_sel),
                .i_prof_inc    ((r_state == IS_RUN) && w_sel),
                .o_src_addr    (w_src_addr[g]),
                .o_src_size    (w_src_size[g]),
                .o_des_addr    (w_des_addr[g]),
                .o_des_size    (w_des_size[g]),
                .o_status      (w_status[g]),
                .o_profile     (w_profile[g]),
                .o_wr_rej      (w_wr_rej[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IS_SCAN;
            r_ptr        <= '0;
            iss_valid    <= 1'b0;
            iss_idx      <= '0;
            iss_src_addr <= '0;
            iss_src_size <= '0;
            iss_des_addr <= '0;
            iss_des_size <= '0;
            busy         <= 1'b0;
            done_pulse   <= 1'b0;
            done_idx     <= '0;
        end else begin
            done_pulse <= 1'b0;
            case (r_state)
                IS_SCAN: begin
                    if (seq_en) begin
                        if (w_status[r_ptr] == ST_PENDING) begin
                            // Descriptor is snapshotted so iss_* stay stable until accepted.
                            r_state      <= IS_ISSUE;
                            iss_valid    <= 1'b1;
                            iss_idx      <= r_ptr;
                            iss_src_addr <= w_src_addr[r_ptr];
                            iss_src_size <= w_src_size[r_ptr];
                            iss_des_addr <= w_des_addr[r_ptr];
                            iss_des_size <= w_des_size[r_ptr];
                        end else begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
                IS_ISSUE: begin
                    if (iss_ready) begin
                        r_state   <= IS_RUN;
                        iss_valid <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                IS_RUN: begin
                    if (exec_done) begin
                        r_state    <= IS_SCAN;
                        busy       <= 1'b0;
                        done_pulse <= 1'b1;
                        done_idx   <= r_ptr;
                        r_ptr      <= w_ptr_next;
                    end
                end
                default: r_state <= IS_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_wr_err  <= 1'b0;
            cfg_rd_data <= '0;
        end else begin
            cfg_wr_err <= |w_wr_rej;
            case (cfg_rd_field)
                c_FLD_SRC_ADDR: cfg_rd_data <= DATA_WIDTH'(w_src_addr[cfg_rd_idx]);
                c_FLD_SRC_SIZE: cfg_rd_data <= DATA_WIDTH'(w_src_size[cfg_rd_idx]);
                c_FLD_DES_ADDR: cfg_rd_data <= DATA_WIDTH'(w_des_addr[cfg_rd_idx]);
                c_FLD_DES_SIZE: cfg_rd_data <= DATA_WIDTH'(w_des_size[cfg_rd_idx]);
                c_RD_STATUS:    cfg_rd_data <= DATA_WIDTH'(w_status[cfg_rd_idx]);
                c_RD_PROFILE:   cfg_rd_data <= DATA_WIDTH'(w_profile[cfg_rd_idx]);
                default:        cfg_rd_data <= '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slot_bank.sv
// ============================================================================
// Module : tb_slot_bank
// Self-checking bench for slot_bank: vector table, random model runs, corners
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_slot_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_idx;
    logic [2:0]  cfg_wr_field;
    logic [31:0] cfg_wr_data;
    logic [1:0]  cfg_rd_idx;
    logic [2:0]  cfg_rd_field;
    logic        seq_en, iss_ready, exec_done;

    logic        cfg_wr_err, iss_valid, busy, done_pulse;
    logic [31:0] cfg_rd_data, iss_src_addr, iss_des_addr;
    logic [25:0] iss_src_size, iss_des_size;
    logic [1:0]  iss_idx, done_idx;

    logic        d4_wr_err, d4_valid, d4_busy, d4_done_pulse;
    logic [31:0] d4_rd_data, d4_src_addr, d4_des_addr;
    logic [25:0] d4_src_size, d4_des_size;
    logic [1:0]  d4_iss_idx, d4_done_idx;

    always #5 clk = ~clk;

    slot_bank dut (
        .clk(clk), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_field(cfg_wr_field),
        .cfg_wr_data(cfg_wr_data), .cfg_wr_err(cfg_wr_err),
        .cfg_rd_idx(cfg_rd_idx), .cfg_rd_field(cfg_rd_field), .cfg_rd_data(cfg_rd_data),
        .seq_en(seq_en), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_idx(iss_idx),
        .iss_src_addr(iss_src_addr), .iss_src_size(iss_src_size),
        .iss_des_addr(iss_des_addr), .iss_des_size(iss_des_size),
        .exec_done(exec_done), .busy(busy), .done_pulse(done_pulse), .done_idx(done_idx)
    );

    // Narrow-profile instance sharing the same stimulus, used for saturation.
    slot_bank #(.PROFILE_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_field(cfg_wr_field),
        .cfg_wr_data(cfg_wr_data), .cfg_wr_err(d4_wr_err),
        .cfg_rd_idx(cfg_rd_idx), .cfg_rd_field(cfg_rd_field), .cfg_rd_data(d4_rd_data),
        .seq_en(seq_en), .iss_valid(d4_valid), .iss_ready(iss_ready), .iss_idx(d4_iss_idx),
        .iss_src_addr(d4_src_addr), .iss_src_size(d4_src_size),
        .iss_des_addr(d4_des_addr), .iss_des_size(d4_des_size),
        .exec_done(exec_done), .busy(d4_busy), .done_pulse(d4_done_pulse), .done_idx(d4_done_idx)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: plain per-slot arrays.
    logic [31:0] m_sa [4];
    logic [31:0] m_ss [4];
    logic [31:0] m_da [4];
    logic [31:0] m_ds [4];
    int          m_st [4];
    longint      m_pf [4];
    int          m_ptr;

    typedef struct {
        logic        we;
        logic [1:0]  wi;
        logic [2:0]  wf;
        logic [31:0] wd;
        logic [1:0]  ri;
        logic [2:0]  rf;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_sa[i] = '0; m_ss[i] = '0; m_da[i] = '0; m_ds[i] = '0;
            m_st[i] = 0;  m_pf[i] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_field = '0; cfg_wr_data = '0;
        cfg_rd_idx = '0; cfg_rd_field = '0;
        seq_en = 1'b0; iss_ready = 1'b0; exec_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    function automatic logic [31:0] mread(input int i, input int f);
        case (f)
            0: return m_sa[i];
            1: return m_ss[i];
            2: return m_da[i];
            3: return m_ds[i];
            4: return 32'(m_st[i]);
            5: return 32'(m_pf[i]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic mwrite(input int i, input int f, input logic [31:0] d, output logic rej);
        rej = (f > 5) || (m_st[i] == 2);
        if (!rej) begin
            case (f)
                0: m_sa[i] = d;
                1: m_ss[i] = d & 32'h03FF_FFFF;
                2: m_da[i] = d;
                3: m_ds[i] = d & 32'h03FF_FFFF;
                4: begin m_st[i] = 1; m_pf[i] = 0; end
                default: m_st[i] = 0;
            endcase
        end
    endtask

    function automatic int next_pending();
        for (int k = 0; k < 4; k++) begin
            if (m_st[(m_ptr + k) % 4] == 1) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic wr(input int i, input int f, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_wr_idx = 2'(i); cfg_wr_field = 3'(f); cfg_wr_data = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    task automatic rd(input int i, input int f);
        cfg_rd_idx = 2'(i); cfg_rd_field = 3'(f);
        tick();
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!iss_valid && n < max) begin
            tick();
            n++;
        end
        if (!iss_valid) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_valid: iss_valid=0 after %0d cycles, expected 1", max);
        end
    endtask

    // Accept the offered slot and report exec_done run_len cycles after the handshake.
    task automatic run_slot(input int exp_idx, input int run_len);
        wait_valid(40);
        chk("run_iss_idx", iss_idx, exp_idx);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_valid_drop", iss_valid, 0);
        repeat (run_len - 1) tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("run_done_pulse", done_pulse, 1);
        chk("run_done_idx", done_idx, exp_idx);
        chk("run_busy_clr", busy, 0);
    endtask

    vec_t vecs [12];
    logic exp_err;
    logic [31:0] exp_rd;

    initial begin
        vecs[0]  = '{1, 2, 0, 32'h1000_0000, 2, 0, 32'h0,          0};
        vecs[1]  = '{1, 2, 1, 32'h40,        2, 0, 32'h1000_0000,  0};
        vecs[2]  = '{1, 2, 2, 32'h2000_0000, 2, 1, 32'h40,         0};
        vecs[3]  = '{1, 2, 3, 32'hFFFF_FFFF, 2, 2, 32'h2000_0000,  0};
        vecs[4]  = '{0, 0, 0, 32'h0,         2, 3, 32'h03FF_FFFF,  0};
        vecs[5]  = '{0, 0, 0, 32'h0,         2, 4, 32'h0,          0};
        vecs[6]  = '{1, 2, 7, 32'h5,         2, 0, 32'h1000_0000,  1};
        vecs[7]  = '{1, 2, 6, 32'h5,         2, 6, 32'h0,          1};
        vecs[8]  = '{1, 2, 4, 32'h0,         2, 4, 32'h0,          0};
        vecs[9]  = '{1, 2, 5, 32'h0,         2, 4, 32'h1,          0};
        vecs[10] = '{0, 0, 0, 32'h0,         2, 4, 32'h0,          0};
        vecs[11] = '{0, 0, 0, 32'h0,         2, 0, 32'h1000_0000,  0};

        do_reset();
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_pulse", done_pulse, 0);
        chk("rst_wr_err", cfg_wr_err, 0);
        chk("rst_rd_data", cfg_rd_data, 0);
        chk("rst_iss_src", iss_src_addr, 0);

        for (int v = 0; v < 12; v++) begin
            cfg_wr_en = vecs[v].we; cfg_wr_idx = vecs[v].wi;
            cfg_wr_field = vecs[v].wf; cfg_wr_data = vecs[v].wd;
            cfg_rd_idx = vecs[v].ri; cfg_rd_field = vecs[v].rf;
            tick();
            chk($sformatf("vec%0d_rd", v), cfg_rd_data, vecs[v].exp_rd);
            chk($sformatf("vec%0d_err", v), cfg_wr_err, vecs[v].exp_err);
        end
        cfg_wr_en = 1'b0;

        // Random config traffic with the issuer idle.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            cfg_wr_en = 1'($urandom_range(0, 1));
            cfg_wr_idx = 2'($urandom_range(0, 3));
            cfg_wr_field = 3'($urandom_range(0, 7));
            cfg_wr_data = $urandom;
            cfg_rd_idx = 2'($urandom_range(0, 3));
            cfg_rd_field = 3'($urandom_range(0, 7));
            exp_rd = mread(int'(cfg_rd_idx), int'(cfg_rd_field));
            exp_err = 1'b0;
            if (cfg_wr_en) mwrite(int'(cfg_wr_idx), int'(cfg_wr_field), cfg_wr_data, exp_err);
            tick();
            chk("p1_rd", cfg_rd_data, exp_rd);
            chk("p1_err", cfg_wr_err, exp_err);
        end
        cfg_wr_en = 1'b0;

        // Random issuing of whatever is pending, against the model.
        begin
            bit m_run = 0;
            bit was_hold = 0;
            bit exp_done;
            bit hs;
            int ridx = 0;
            int np;
            int cyc = 0;
            while ((next_pending() >= 0 || m_run) && cyc < 3000) begin
                cyc++;
                seq_en = ($urandom_range(0, 9) < 8);
                iss_ready = 1'($urandom_range(0, 1));
                exec_done = ($urandom_range(0, 4) == 0);
                cfg_rd_idx = 2'($urandom_range(0, 3));
                cfg_rd_field = 3'($urandom_range(0, 7));
                exp_rd = mread(int'(cfg_rd_idx), int'(cfg_rd_field));
                np = next_pending();
                if (was_hold) chk("p2_valid_held", iss_valid, 1);
                if (m_run) chk("p2_valid_while_busy", iss_valid, 0);
                if (iss_valid && !m_run) begin
                    chk("p2_iss_idx", iss_idx, np);
                    if (np >= 0) begin
                        chk("p2_iss_src", iss_src_addr, m_sa[np]);
                        chk("p2_iss_dsz", iss_des_size, m_ds[np]);
                    end
                end
                hs = iss_valid && iss_ready && !m_run && (np >= 0);
                was_hold = iss_valid && !iss_ready;
                exp_done = 0;
                if (m_run) begin
                    m_pf[ridx]++;
                    if (exec_done) begin
                        m_st[ridx] = 3;
                        m_run = 0;
                        exp_done = 1;
                        m_ptr = (ridx + 1) % 4;
                    end
                end else if (hs) begin
                    ridx = np;
                    m_st[np] = 2;
                    m_run = 1;
                end
                tick();
                chk("p2_busy", busy, m_run);
                chk("p2_done_pulse", done_pulse, exp_done);
                if (exp_done) chk("p2_done_idx", done_idx, ridx);
                chk("p2_rd", cfg_rd_data, exp_rd);
            end
            if (cyc >= 3000) chk("p2_timeout", 0, 1);
            seq_en = 0; iss_ready = 0; exec_done = 0;
        end

        // Single armed slot: scan, issue latency, 10-cycle run profile.
        do_reset();
        seq_en = 1'b1;
        wr(1, 4, 0);
        chk("d1_valid_early", iss_valid, 0);
        tick();
        chk("d1_valid", iss_valid, 1);
        chk("d1_idx", iss_idx, 1);
        run_slot(1, 10);
        tick();
        chk("d1_pulse_one_cycle", done_pulse, 0);
        rd(1, 5);
        chk("d1_profile", cfg_rd_data, 10);
        rd(1, 4);
        chk("d1_status", cfg_rd_data, 3);

        // Two armed slots, sequencer stalls, plus rejected writes while running.
        do_reset();
        wr(0, 0, 32'hA000_0000);
        wr(0, 3, 32'h123);
        wr(0, 4, 0);
        wr(3, 0, 32'hB000_0000);
        wr(3, 4, 0);
        seq_en = 1'b1;
        wait_valid(20);
        seq_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("d2_hold_valid", iss_valid, 1);
            chk("d2_hold_idx", iss_idx, 0);
            chk("d2_hold_src", iss_src_addr, 32'hA000_0000);
            chk("d2_hold_dsz", iss_des_size, 32'h123);
            tick();
        end
        seq_en = 1'b1;
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("d2_busy", busy, 1);
        wr(0, 2, 32'hDEAD_BEEF);
        chk("d3_run_wr_err", cfg_wr_err, 1);
        wr(1, 7, 32'h1);
        chk("d3_code7_err", cfg_wr_err, 1);
        rd(0, 2);
        chk("d3_des_unchanged", cfg_rd_data, 0);
        chk("d3_err_clears", cfg_wr_err, 0);
        rd(0, 4);
        chk("d3_status_running", cfg_rd_data, 2);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        chk("d2_done0", done_pulse, 1);
        chk("d2_done0_idx", done_idx, 0);
        wait_valid(20);
        chk("d2_second_src", iss_src_addr, 32'hB000_0000);
        run_slot(3, 3);

        // Reset while running aborts without a completion pulse.
        do_reset();
        seq_en = 1'b1;
        wr(1, 4, 0);
        wait_valid(20);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        exec_done = 1'b1;
        tick();
        reset = 1'b0;
        exec_done = 1'b0;
        seq_en = 1'b0;
        chk("d4_busy", busy, 0);
        chk("d4_done_pulse", done_pulse, 0);
        chk("d4_iss_valid", iss_valid, 0);
        chk("d4_rd_data", cfg_rd_data, 0);
        chk("d4_iss_idx", iss_idx, 0);
        for (int s = 0; s < 4; s++) begin
            rd(s, 4);
            chk("d4_status_empty", cfg_rd_data, 0);
            chk("d4_no_pulse", done_pulse, 0);
        end

        // 20-cycle run: full-width counter reads 20, 4-bit counter saturates at 15.
        do_reset();
        seq_en = 1'b1;
        wr(0, 4, 0);
        run_slot(0, 20);
        rd(0, 5);
        chk("d5_profile_wide", cfg_rd_data, 20);
        chk("d5_profile_sat", d4_rd_data, 15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slot_bank.md
# slot_bank

Parametrised bank of NUM_SLOTS reconfiguration/transfer descriptors with a built-in round-robin issuer. Software writes each slot's fields and arms it through an indexed config port. The issuer then hands armed slots, in slot order, to the DMA/DFX sequencer over a valid/ready channel. Per-slot status and a saturating execution-cycle profile counter are read back through a registered read port.

## Interface
Parameters:
- NUM_SLOTS, 4, number of descriptor slots (>=2)
- IDX_WIDTH, $clog2(NUM_SLOTS), slot index width
- SRC_ADDR_WIDTH, 32, source address width
- SRC_SIZE_WIDTH, 26, source size width
- DST_ADDR_WIDTH, 32, destination address width
- DST_SIZE_WIDTH, 26, destination size width
- PROFILE_WIDTH, 32, profile counter width
- DATA_WIDTH, 32, config data width; must be >= every field width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cfg_wr_en  in  1  config write strobe
- cfg_wr_idx  in  IDX_WIDTH  target slot
- cfg_wr_field  in  3  0 src_addr, 1 src_size, 2 des_addr, 3 des_size, 4 arm, 5 clear
- cfg_wr_data  in  DATA_WIDTH  write data; LSBs used
- cfg_wr_err  out  1  one-cycle pulse: previous write rejected
- cfg_rd_idx  in  IDX_WIDTH  read slot
- cfg_rd_field  in  3  0–3 as write, 4 status, 5 profile
- cfg_rd_data  out  DATA_WIDTH  registered read data, zero-extended
- seq_en  in  1  issuer enable
- iss_valid  out  1  descriptor offered
- iss_ready  in  1  sequencer accepts
- iss_idx  out  IDX_WIDTH  offered slot
- iss_src_addr / iss_src_size / iss_des_addr / iss_des_size  out  field widths  offered descriptor
- exec_done  in  1  sequencer finished the running slot
- busy  out  1  a slot is RUNNING
- done_pulse  out  1  one-cycle completion pulse
- done_idx  out  IDX_WIDTH  slot that completed

## Operation
- Slot status (2 bits): EMPTY=0, PENDING=1, RUNNING=2, DONE=3.
- Field writes 0–3 store the truncated data and leave status unchanged.
- Arm (4) sets the slot PENDING and clears its profile counter.
- Clear (5) sets the slot EMPTY. Fields are retained.
- Any write to a RUNNING slot is rejected: no state change, and cfg_wr_err pulses the next cycle.
- Field codes 6–7 are also rejected with cfg_wr_err.
- Unused read codes return 0.
- Issuer FSM:
  - SCAN: ptr=0 at reset. Each cycle with seq_en=1, if slot[ptr] is PENDING, go to ISSUE. Otherwise advance ptr by 1, wrapping from NUM_SLOTS-1 to 0. With seq_en=0, hold.
  - ISSUE: iss_valid=1 with slot[ptr] fields. Hold iss_valid and all iss_* stable until iss_valid&&iss_ready, even if seq_en falls. On the handshake: slot→RUNNING, go to RUN.
  - RUN: busy=1 and the profile counter increments each cycle, saturating at all-ones. On exec_done: slot→DONE, done_pulse=1, done_idx=ptr, ptr advances, go to SCAN.
- exec_done outside RUN is ignored.
- Only one slot is RUNNING at any time.

## Timing
- Reset values: all slot fields, status and profile 0; ptr 0; state SCAN; every output 0.
- cfg write in cycle t takes effect at t+1. The issuer samples registered status, so a same-cycle arm is not seen until t+1.
- cfg_rd_data at t+1 reflects state at the end of cycle t. A write and a read to the same slot/field in the same cycle returns the old value.
- Arm at t with ptr already on that slot, in SCAN with seq_en=1: SCAN detects PENDING at t+1, iss_valid rises at t+2.
- Handshake at cycle h: state RUN, busy=1 and the first profile increment all occur at h+1.
- exec_done at cycle d: the profile includes cycle d. done_pulse, status DONE and busy=0 occur at d+1.
- exec_done in the same cycle as the handshake is ignored.
- Reset mid-operation aborts immediately, with no done_pulse.

## Structure
- slot_pkg: field codes, status encodings, issuer state enum, PROFILE saturation constant.
- Sub-module slot_entry:
  - contents: one slot's fields, status and profile counter, with write decode and reject flag;
  - instantiation: NUM_SLOTS times via generate.
- The top level holds the issuer FSM, ptr and the read mux.

## Test plan
- Write src_addr=0x1000_0000, src_size=0x40 and des fields to slot 2, then read back: cfg_rd_data matches one cycle later, and status reads 0.
- Arm slot 1 only, seq_en=1: ptr scans 0→1, iss_valid appears with iss_idx=1; iss_ready at h gives busy at h+1.
- RUN with exec_done 10 cycles after the handshake: profile reads 10, done_pulse=1 with done_idx=1, status 3.
- Arm slots 0 and 3 with iss_ready low for 5 cycles: iss_* stay stable. Slot 0 issues first, slot 3 follows after its done.
- Write des_addr to the RUNNING slot: cfg_wr_err=1 the next cycle and the value is unchanged. Field code 7 also raises cfg_wr_err.
- Assert reset during RUN: all outputs are 0 the next cycle, there is no done_pulse, and every status reads EMPTY.
- PROFILE_WIDTH=4 with a 20-cycle run: profile saturates at 15.
